// File: rtl/division_4bits_ctrl_if.sv
// Handshake bundle for the signed 4-bit divider controller:
// operand/start, result/status, and the shared-negator request lines.
interface division_4bits_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;
  logic             comp_sel;
  logic [WIDTH-1:0] comp_a;
  logic             comp_finish;
  logic [WIDTH-1:0] comp_sum;

  modport master (
    output start, a, b, comp_finish, comp_sum,
    input  busy, done, quotient, remainder,
    input  div_by_zero, overflow, comp_sel, comp_a
  );

  modport slave (
    input  start, a, b, comp_finish, comp_sum,
    output busy, done, quotient, remainder,
    output div_by_zero, overflow, comp_sel, comp_a
  );
endinterface

// File: rtl/division_4bits_ctrl.sv
// Signed 4-bit restoring divider controller using a shared negation unit.
// Define DIV_INTERNAL_NEG_EN to negate internally and drop the handshake.
module division_4bits_ctrl #(
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  division_4bits_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE, CHK, NEG_A, NEG_B, DIV,
    NEG_Q, NEG_R, REL, DONE
  } st_t;

  st_t st, st_n, st_div, st_q, st_neg;
  logic [3:0] ra, rb, ma, mb;
  logic [3:0] p, p_n, q_nx, neg_v;
  logic [4:0] p_sh;
  logic [CW-1:0] cnt;
  logic ge, fire, sdiff;

  assign sdiff = ra[3] ^ rb[3];
  assign p_sh = {p, ma[3]};
  assign ge = p_sh >= {1'b0, mb};
  // below |b| (<= 8) the top bit of p_sh is always clear
  assign p_n = ge ? 4'(p_sh - {1'b0, mb})
                  : p_sh[3:0];
  assign q_nx = {bus.quotient[2:0], ge};

  assign st_div = (sdiff && q_nx != 4'h0) ? NEG_Q
                : (ra[3] && p_n != 4'h0) ? NEG_R
                : DONE;
  assign st_q = (ra[3] && bus.remainder != 4'h0)
              ? NEG_R : DONE;

  always_comb begin
    st_neg = DONE;
    unique case (st)
      NEG_A:   st_neg = rb[3] ? NEG_B : DIV;
      NEG_B:   st_neg = DIV;
      NEG_Q:   st_neg = st_q;
      default: st_neg = DONE;
    endcase
  end

`ifdef DIV_INTERNAL_NEG_EN
  logic [3:0] opnd;
  logic unused;

  assign unused = ^{bus.comp_finish, bus.comp_sum};
  assign bus.comp_sel = 1'b0;
  assign bus.comp_a = 4'h0;
  assign fire = 1'b1;

  always_comb begin
    opnd = 4'h0;
    unique case (st)
      NEG_A:   opnd = ra;
      NEG_B:   opnd = rb;
      NEG_Q:   opnd = bus.quotient;
      NEG_R:   opnd = bus.remainder;
      default: opnd = 4'h0;
    endcase
  end

  assign neg_v = 4'(~opnd + 4'd1);
`else
  st_t st_ret;
  logic sel_n;
  logic [3:0] opnd_n;

  assign fire = bus.comp_sel && bus.comp_finish;
  assign neg_v = bus.comp_sum;
  assign sel_n = (st_n == NEG_A) || (st_n == NEG_B)
              || (st_n == NEG_Q) || (st_n == NEG_R);

  // leaving DIV the new q/r are not yet in the output regs
  always_comb begin
    opnd_n = 4'h0;
    unique case (st_n)
      NEG_A:   opnd_n = ra;
      NEG_B:   opnd_n = rb;
      NEG_Q:   opnd_n = (st == DIV) ? q_nx : bus.quotient;
      NEG_R:   opnd_n = (st == DIV) ? p_n : bus.remainder;
      default: opnd_n = 4'h0;
    endcase
  end
`endif

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE: if (bus.start) st_n = CHK;
      CHK: begin
        if (rb == 4'h0)  st_n = DONE;
        else if (ra[3])  st_n = NEG_A;
        else if (rb[3])  st_n = NEG_B;
        else             st_n = DIV;
      end
      NEG_A, NEG_B, NEG_Q, NEG_R: begin
`ifdef DIV_INTERNAL_NEG_EN
        if (fire) st_n = st_neg;
`else
        if (fire) st_n = REL;
`endif
      end
      REL: begin
`ifdef DIV_INTERNAL_NEG_EN
        st_n = IDLE;
`else
        if (!bus.comp_finish) st_n = st_ret;
`endif
      end
      DIV:     if (cnt == LAST) st_n = st_div;
      DONE:    st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      ra <= 4'h0;
      rb <= 4'h0;
      ma <= 4'h0;
      mb <= 4'h0;
      p <= 4'h0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.quotient <= 4'h0;
      bus.remainder <= 4'h0;
      bus.div_by_zero <= 1'b0;
      bus.overflow <= 1'b0;
`ifndef DIV_INTERNAL_NEG_EN
      st_ret <= IDLE;
      bus.comp_sel <= 1'b0;
      bus.comp_a <= 4'h0;
`endif
    end else begin
      st <= st_n;
      bus.done <= 1'b0;
`ifndef DIV_INTERNAL_NEG_EN
      bus.comp_sel <= sel_n;
      bus.comp_a <= opnd_n;
`endif
      unique case (st)
        IDLE: if (bus.start) begin
          ra <= bus.a;
          rb <= bus.b;
          bus.div_by_zero <= 1'b0;
          bus.overflow <= 1'b0;
          bus.busy <= 1'b1;
        end
        CHK: begin
          ma <= ra;
          mb <= rb;
          p <= 4'h0;
          cnt <= '0;
          bus.overflow <= (ra == 4'h8) && (rb == 4'hF);
          if (rb == 4'h0) begin
            bus.div_by_zero <= 1'b1;
            bus.quotient <= 4'h0;
            bus.remainder <= ra;
          end
        end
        NEG_A, NEG_B, NEG_Q, NEG_R: if (fire) begin
          if (st == NEG_A)      ma <= neg_v;
          else if (st == NEG_B) mb <= neg_v;
          else if (st == NEG_Q) bus.quotient <= neg_v;
          else                  bus.remainder <= neg_v;
`ifndef DIV_INTERNAL_NEG_EN
          st_ret <= st_neg;
`endif
        end
        DIV: begin
          p <= p_n;
          ma <= {ma[2:0], 1'b0};
          bus.quotient <= q_nx;
          bus.remainder <= p_n;
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
